apb_drra_io_bridge: RTL and testbench

//  Parametrised APB3 slave for the DRRA fabric: instruction load, wide IO in/out buffers, call/ret control.

---
 rtl/apb_drra_pkg.sv | 30 +++
 rtl/io_buffer.sv | 41 ++++
 rtl/apb_drra_io_bridge.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_apb_drra_io_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_drra_pkg.sv
// ---------------------------------------------------------------------------
// apb_drra_pkg
// Shared definitions for the APB-to-DRRA IO bridge:
//   - CTRL register offsets inside the control region
//   - STATUS register bit positions
//   - states of the DOUT line-cache read FSM
// ---------------------------------------------------------------------------
package apb_drra_pkg;

    // Byte offsets within the control region.
    localparam logic [11:0] CTRL_SEL    = 12'h000;
    localparam logic [11:0] CTRL_CALL   = 12'h004;
    localparam logic [11:0] CTRL_STATUS = 12'h008;
    localparam logic [11:0] CTRL_IRQEN  = 12'h00C;

    // STATUS register bit positions.
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DROP = 2;
    localparam int ST_HIT  = 3;

    // DOUT read path: fetch a full IO word into the line cache, then answer.
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FILL,
        RESP
    } rd_state_e;

endpackage

// File: rtl/io_buffer.sv
// ---------------------------------------------------------------------------
// io_buffer
// Single-port IO word buffer with one cycle read latency.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (read register only)
//   i_en      : port enable
//   i_we      : 1 = write i_wdata to i_addr, 0 = read i_addr
//   i_addr    : word address
//   i_wdata   : write word
//   o_rdata   : read word, valid the cycle after a read
// ---------------------------------------------------------------------------
module io_buffer #(
    parameter int AW = 6,
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // NOTE: the storage array is deliberately left without reset so it maps
    // onto a RAM macro; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_en && i_we) r_mem[i_addr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)                r_rdata <= '0;
        else if (i_en && !i_we) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_drra_io_bridge.sv
// ---------------------------------------------------------------------------
// apb_drra_io_bridge
// APB3 slave bridging the SoC interconnect to the DRRA array: instruction
// load, wide IO in/out buffers with chunk assembly and a DOUT line cache,
// and a call/ret handshake with sticky status and interrupt.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   i_psel/i_penable/i_pwrite/i_paddr/i_pwdata, o_prdata/o_pready/o_pslverr
//                                    : APB3 slave
//   o_call, i_ret, o_irq             : launch pulse, row done, interrupt
//   i_io_en_in/i_io_addr_in/o_io_data_in    : DRRA reads of the in-buffer
//   i_io_en_out/i_io_addr_out/i_io_data_out : DRRA writes of the out-buffer
//   o_instr_data_in/addr/hops/en     : instruction load strobe per row
// ---------------------------------------------------------------------------
module apb_drra_io_bridge
    import apb_drra_pkg::*;
#(
    parameter int APB_AW           = 32,
    parameter int APB_DW           = 32,
    parameter int ROWS             = 1,
    parameter int COLS             = 2,
    parameter int IO_ADDR_WIDTH    = 6,
    parameter int IO_DATA_WIDTH    = 256,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int INSTR_ADDR_WIDTH = 6,
    parameter int INSTR_HOPS_WIDTH = 4,
    parameter int INSTR_BASE       = 'h0000,
    parameter int DIN_BASE         = 'h1000,
    parameter int DOUT_BASE        = 'h2000,
    parameter int CTRL_BASE        = 'h3000,
    parameter int REGION_BYTES     = 'h1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_psel,
    input  logic                               i_penable,
    input  logic                               i_pwrite,
    input  logic [APB_AW-1:0]                  i_paddr,
    input  logic [APB_DW-1:0]                  i_pwdata,
    output logic [APB_DW-1:0]                  o_prdata,
    output logic                               o_pready,
    output logic                               o_pslverr,
    output logic [ROWS-1:0]                    o_call,
    input  logic [ROWS-1:0]                    i_ret,
    output logic                               o_irq,
    input  logic [COLS-1:0]                    i_io_en_in,
    input  logic [COLS*IO_ADDR_WIDTH-1:0]      i_io_addr_in,
    output logic [COLS*IO_DATA_WIDTH-1:0]      o_io_data_in,
    input  logic [COLS-1:0]                    i_io_en_out,
    input  logic [COLS*IO_ADDR_WIDTH-1:0]      i_io_addr_out,
    input  logic [COLS*IO_DATA_WIDTH-1:0]      i_io_data_out,
    output logic [ROWS*INSTR_DATA_WIDTH-1:0]   o_instr_data_in,
    output logic [ROWS*INSTR_ADDR_WIDTH-1:0]   o_instr_addr_in,
    output logic [ROWS*INSTR_HOPS_WIDTH-1:0]   o_instr_hops_in,
    output logic [ROWS-1:0]                    o_instr_en_in
);

    localparam int NUM_CHUNKS = IO_DATA_WIDTH / APB_DW;
    localparam int BYTE_W     = $clog2(APB_DW / 8);
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LINE_LSB   = BYTE_W + $clog2(NUM_CHUNKS);
    localparam logic [APB_AW-1:0] OFF_MASK = APB_AW'(REGION_BYTES - 1);

    // ---------------- address decode ----------------
    // Regions are aligned to REGION_BYTES, so the low 12 bits are the offset.
    logic [APB_AW-1:0]        w_base;
    logic [11:0]              w_off;
    logic [IO_ADDR_WIDTH-1:0] w_line;
    logic [CHUNK_W-1:0]       w_chunk;
    logic w_in_instr, w_in_din, w_in_dout, w_in_ctrl;
    logic w_is_sel, w_is_call, w_is_status, w_is_irqen, w_unmapped;

    assign w_base      = i_paddr & ~OFF_MASK;
    assign w_off       = i_paddr[11:0];
    assign w_line      = w_off[LINE_LSB +: IO_ADDR_WIDTH];
    assign w_chunk     = w_off[BYTE_W +: CHUNK_W];
    assign w_in_instr  = (w_base == APB_AW'(INSTR_BASE));
    assign w_in_din    = (w_base == APB_AW'(DIN_BASE));
    assign w_in_dout   = (w_base == APB_AW'(DOUT_BASE));
    assign w_in_ctrl   = (w_base == APB_AW'(CTRL_BASE));
    assign w_is_sel    = w_in_ctrl && (w_off == CTRL_SEL);
    assign w_is_call   = w_in_ctrl && (w_off == CTRL_CALL);
    assign w_is_status = w_in_ctrl && (w_off == CTRL_STATUS);
    assign w_is_irqen  = w_in_ctrl && (w_off == CTRL_IRQEN);
    assign w_unmapped  = !(w_in_instr || w_in_din || w_in_dout ||
                           w_is_sel || w_is_call || w_is_status || w_is_irqen);

    // ---------------- control registers ----------------
    logic [15:0]     r_row_sel, r_col_sel;
    logic            r_busy, r_done, r_drop, r_hit_last, r_irqen, r_irq;
    logic [ROWS-1:0] r_call;
    rd_state_e       r_state;
    logic            r_cache_valid, r_commit_pending;
    logic [IO_ADDR_WIDTH-1:0] r_cache_tag, r_asm_line;
    logic [NUM_CHUNKS-1:0][APB_DW-1:0] r_cache_data, r_asm_data;
    logic [NUM_CHUNKS-1:0]    r_asm_valid, w_valid_next;

    // ---------------- row/column selection ----------------
    logic [ROWS-1:0]          w_row_oh;
    logic [COLS-1:0]          w_col_oh;
    logic [IO_ADDR_WIDTH-1:0] w_rd_addr, w_wr_addr;
    logic [IO_DATA_WIDTH-1:0] w_wr_data;
    logic                     w_drra_rd, w_drra_wr;

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_rd_addr = '0;
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int r = 0; r < ROWS; r++) w_row_oh[r] = (r_row_sel == 16'(r));
        for (int c = 0; c < COLS; c++) begin
            w_col_oh[c] = (r_col_sel == 16'(c));
            if (w_col_oh[c]) begin
                w_rd_addr = i_io_addr_in[c*IO_ADDR_WIDTH +: IO_ADDR_WIDTH];
                w_wr_addr = i_io_addr_out[c*IO_ADDR_WIDTH +: IO_ADDR_WIDTH];
                w_wr_data = i_io_data_out[c*IO_DATA_WIDTH +: IO_DATA_WIDTH];
            end
        end
    end

    assign w_drra_rd = |(i_io_en_in & w_col_oh);
    assign w_drra_wr = |(i_io_en_out & w_col_oh);

    // ---------------- APB handshake ----------------
    logic w_access, w_din_wr, w_dout_rd, w_hit, w_done, w_err, w_eff;
    logic w_instr_wr, w_din_eff, w_drop;
    logic [APB_DW-1:0] w_rdata;

    assign w_access  = i_psel && i_penable;
    assign w_din_wr  = w_access && i_pwrite && w_in_din;
    assign w_dout_rd = w_access && !i_pwrite && w_in_dout;
    // A DRRA write to the cached line in this very cycle makes the copy stale.
    assign w_hit     = r_cache_valid && (r_cache_tag == w_line) &&
                       !(w_drra_wr && (w_wr_addr == w_line));
    assign o_pready  = !((w_din_wr && r_commit_pending) ||
                         (w_dout_rd && !((r_state == RESP) ||
                                         ((r_state == IDLE) && w_hit))));
    assign w_done    = w_access && o_pready;
    assign w_err     = w_unmapped ||
                       (i_pwrite && w_is_sel && ((i_pwdata[15:0] >= 16'(ROWS)) ||
                                                 (i_pwdata[31:16] >= 16'(COLS)))) ||
                       (i_pwrite && w_is_call && i_pwdata[0] && r_busy);
    assign w_eff      = w_done && !w_err;
    assign o_pslverr  = w_done && w_err;
    assign w_instr_wr = w_eff && i_pwrite && w_in_instr;
    assign w_din_eff  = w_eff && i_pwrite && w_in_din;

    always_comb begin
        w_rdata = '0;
        if (w_is_sel)    w_rdata = APB_DW'({r_col_sel, r_row_sel});
        if (w_is_status) w_rdata = APB_DW'({r_hit_last, r_drop, r_done, r_busy});
        if (w_is_irqen)  w_rdata = APB_DW'(r_irqen);
        if (w_in_dout)   w_rdata = r_cache_data[w_chunk];
    end

    assign o_prdata = (w_done && !i_pwrite) ? w_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_sel  <= '0;
            r_col_sel  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
            r_hit_last <= 1'b0;
            r_irqen    <= 1'b0;
            r_irq      <= 1'b0;
            r_call     <= '0;
        end else begin
            r_call <= '0;
            if (w_eff && i_pwrite && w_is_sel) {r_col_sel, r_row_sel} <= i_pwdata[31:0];
            if (w_eff && i_pwrite && w_is_irqen) r_irqen <= i_pwdata[0];
            if (w_eff && i_pwrite && w_is_call && i_pwdata[0]) begin
                r_call <= w_row_oh;
                r_busy <= 1'b1;
            end
            // Read-to-clear comes first so a same-cycle set wins.
            if (w_eff && !i_pwrite && w_is_status) begin
                r_done <= 1'b0;
                r_drop <= 1'b0;
            end
            if (r_busy && |(i_ret & w_row_oh)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_drop) r_drop <= 1'b1;
            if (w_done && w_dout_rd) r_hit_last <= (r_state == IDLE);
            r_irq <= r_done && r_irqen;
        end
    end

    // ---------------- instruction load ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_instr_en_in   <= '0;
            o_instr_data_in <= '0;
            o_instr_addr_in <= '0;
            o_instr_hops_in <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                o_instr_en_in[r] <= w_instr_wr && w_row_oh[r];
                o_instr_data_in[r*INSTR_DATA_WIDTH +: INSTR_DATA_WIDTH] <=
                    (w_instr_wr && w_row_oh[r]) ? i_pwdata[INSTR_DATA_WIDTH-1:0] : '0;
                o_instr_addr_in[r*INSTR_ADDR_WIDTH +: INSTR_ADDR_WIDTH] <=
                    (w_instr_wr && w_row_oh[r]) ? w_off[2 +: INSTR_ADDR_WIDTH] : '0;
                o_instr_hops_in[r*INSTR_HOPS_WIDTH +: INSTR_HOPS_WIDTH] <=
                    (w_instr_wr && w_row_oh[r]) ? r_col_sel[INSTR_HOPS_WIDTH-1:0] : '0;
            end
        end
    end

    // ---------------- DIN chunk assembler and commit ----------------
    // Once all chunks are valid the valid bits are cleared and the word is
    // held for commit, so "partial line" simply means any valid bit set.
    assign w_drop = w_din_eff && (|r_asm_valid) && (w_line != r_asm_line);

    always_comb begin
        w_valid_next          = w_drop ? '0 : r_asm_valid;
        w_valid_next[w_chunk] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm_valid      <= '0;
            r_asm_line       <= '0;
            r_commit_pending <= 1'b0;
        end else begin
            if (r_commit_pending && !w_drra_rd) r_commit_pending <= 1'b0;
            // A DIN write only completes while no commit is pending.
            if (w_din_eff) begin
                r_asm_data[w_chunk] <= i_pwdata;
                r_asm_line          <= w_line;
                if (&w_valid_next) begin
                    r_commit_pending <= 1'b1;
                    r_asm_valid      <= '0;
                end else begin
                    r_asm_valid <= w_valid_next;
                end
            end
        end
    end

    logic [IO_DATA_WIDTH-1:0] w_in_rdata, w_out_rdata;
    logic [COLS-1:0]          r_in_col_oh;

    io_buffer #(.AW(IO_ADDR_WIDTH), .DW(IO_DATA_WIDTH)) u_in_buf (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_drra_rd || r_commit_pending),
        .i_we    (!w_drra_rd),
        .i_addr  (w_drra_rd ? w_rd_addr : r_asm_line),
        .i_wdata (r_asm_data),
        .o_rdata (w_in_rdata)
    );

    // Read data is steered to the column that issued the read.
    always_ff @(posedge clk) begin
        if (rst)            r_in_col_oh <= '0;
        else if (w_drra_rd) r_in_col_oh <= w_col_oh;
    end

    always_comb begin
        for (int c = 0; c < COLS; c++)
            o_io_data_in[c*IO_DATA_WIDTH +: IO_DATA_WIDTH] = r_in_col_oh[c] ? w_in_rdata : '0;
    end

    // ---------------- DOUT line cache ----------------
    io_buffer #(.AW(IO_ADDR_WIDTH), .DW(IO_DATA_WIDTH)) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_drra_wr || (r_state == FETCH)),
        .i_we    (w_drra_wr),
        .i_addr  (w_drra_wr ? w_wr_addr : w_line),
        .i_wdata (w_wr_data),
        .o_rdata (w_out_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cache_valid <= 1'b0;
            r_cache_tag   <= '0;
        end else begin
            if (w_drra_wr && (w_wr_addr == r_cache_tag)) r_cache_valid <= 1'b0;
            case (r_state)
                IDLE:  if (w_dout_rd && !w_hit) r_state <= FETCH;
                // DRRA writes own the port; the fetch read waits for a free cycle.
                FETCH: if (!w_drra_wr) r_state <= FILL;
                // A write landing on the line just read makes the read stale.
                FILL: begin
                    if (w_drra_wr && (w_wr_addr == w_line)) begin
                        r_state <= FETCH;
                    end else begin
                        r_cache_data  <= w_out_rdata;
                        r_cache_tag   <= w_line;
                        r_cache_valid <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_call = r_call;
    assign o_irq  = r_irq;

endmodule

// File: tb/tb_apb_drra_io_bridge.sv
// Directed bench for apb_drra_io_bridge with the default parameter set
// (32-bit APB, 256-bit IO words = 8 chunks, 1 row, 2 columns).
module tb_apb_drra_io_bridge;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata, prdata;
    logic          pready, pslverr;
    logic [0:0]    call, ret, instr_en;
    logic          irq;
    logic [1:0]    io_en_in, io_en_out;
    logic [11:0]   io_addr_in, io_addr_out;
    logic [511:0]  io_data_in, io_data_out;
    logic [31:0]   instr_data;
    logic [5:0]    instr_addr;
    logic [3:0]    instr_hops;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0]  rd;
    logic         er;
    int           wt;
    logic [255:0] exp_word;

    always #5 clk = ~clk;

    apb_drra_io_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .i_psel          (psel),
        .i_penable       (penable),
        .i_pwrite        (pwrite),
        .i_paddr         (paddr),
        .i_pwdata        (pwdata),
        .o_prdata        (prdata),
        .o_pready        (pready),
        .o_pslverr       (pslverr),
        .o_call          (call),
        .i_ret           (ret),
        .o_irq           (irq),
        .i_io_en_in      (io_en_in),
        .i_io_addr_in    (io_addr_in),
        .o_io_data_in    (io_data_in),
        .i_io_en_out     (io_en_out),
        .i_io_addr_out   (io_addr_out),
        .i_io_data_out   (io_data_out),
        .o_instr_data_in (instr_data),
        .o_instr_addr_in (instr_addr),
        .o_instr_hops_in (instr_hops),
        .o_instr_en_in   (instr_en)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // One APB transfer; returns read data, PSLVERR and the number of wait states.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int waits);
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        #4;
        while (!pready && waits < 50) begin
            waits++;
            @(posedge clk); #5;
        end
        if (!pready) check("apb_timeout", 1'b0, 1'b1);
        else begin
            rdata = prdata;
            err   = pslverr;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic drra_read(input logic [5:0] line);
        @(posedge clk); #1;
        io_en_in = 2'b10; io_addr_in[11:6] = line;
        @(posedge clk); #1;
        io_en_in = 2'b00;
        #3;
    endtask

    task automatic drra_write(input logic [5:0] line, input logic [31:0] base);
        @(posedge clk); #1;
        io_en_out = 2'b10; io_addr_out[11:6] = line;
        for (int k = 0; k < 8; k++) io_data_out[256 + k*32 +: 32] = base + k;
        @(posedge clk); #1;
        io_en_out = 2'b00;
    endtask

    function automatic logic [31:0] din_addr(input int line, input int chunk);
        return 32'h1000 + 32'(line * 32 + chunk * 4);
    endfunction

    function automatic logic [31:0] dout_addr(input int line, input int chunk);
        return 32'h2000 + 32'(line * 32 + chunk * 4);
    endfunction

    initial begin
        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        ret = 0; io_en_in = 0; io_addr_in = 0; io_en_out = 0; io_addr_out = 0; io_data_out = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        check("rst_pready", pready, 1);
        check("rst_prdata", prdata, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_call", call, 0);
        check("rst_irq", irq, 0);
        check("rst_instr_en", instr_en, 0);
        check("rst_io_data_in", io_data_in, 0);

        // Instruction load with row 0, column 1 selected.
        apb(1, 32'h3000, 32'h0001_0000, rd, er, wt);
        check("sel_ok_err", er, 0);
        apb(1, 32'h0008, 32'h0000_DEAD, rd, er, wt);
        check("instr_waits", wt, 0);
        #3;
        check("instr_en", instr_en, 1);
        check("instr_addr", instr_addr, 2);
        check("instr_hops", instr_hops, 1);
        check("instr_data", instr_data, 32'hDEAD);
        @(posedge clk); #4;
        check("instr_en_pulse", instr_en, 0);
        apb(0, 32'h0008, 0, rd, er, wt);
        check("instr_read_zero", rd, 0);

        // Line 3 assembled from chunks 7..0.
        for (int k = 7; k >= 0; k--) begin
            apb(1, din_addr(3, k), 32'hC0DE_0300 + k, rd, er, wt);
            exp_word[k*32 +: 32] = 32'hC0DE_0300 + k;
        end
        // Hold a DRRA read so the commit stalls, then a DIN write must wait.
        io_en_in = 2'b10; io_addr_in[11:6] = 6'd0;
        fork
            apb(1, din_addr(1, 0), 32'hAAAA_0100, rd, er, wt);
            begin repeat (4) @(posedge clk); #1 io_en_in = 2'b00; end
        join
        check("din_pending_waits", wt > 0, 1);
        drra_read(6'd3);
        check("din_line3_word", io_data_in[511:256], exp_word);
        check("din_other_col", io_data_in[255:0], 0);

        // Partial line 1 abandoned by a write to line 2.
        for (int k = 1; k < 4; k++) apb(1, din_addr(1, k), 32'hAAAA_0100 + k, rd, er, wt);
        apb(1, din_addr(2, 0), 32'hBBBB_0200, rd, er, wt);
        apb(0, 32'h3008, 0, rd, er, wt);
        check("status_drop", rd, 32'h4);
        apb(0, 32'h3008, 0, rd, er, wt);
        check("status_cleared", rd, 32'h0);
        for (int k = 1; k < 8; k++) apb(1, din_addr(2, k), 32'hBBBB_0200 + k, rd, er, wt);
        for (int k = 0; k < 8; k++) exp_word[k*32 +: 32] = 32'hBBBB_0200 + k;
        drra_read(6'd2);
        check("din_line2_word", io_data_in[511:256], exp_word);
        apb(0, din_addr(2, 0), 0, rd, er, wt);
        check("din_read_zero", rd, 0);
        check("din_read_okay", er, 0);

        // DOUT line cache.
        drra_write(6'd5, 32'h5500_0000);
        apb(0, dout_addr(5, 0), 0, rd, er, wt);
        check("dout_miss_waits", wt >= 2, 1);
        check("dout_miss_data", rd, 32'h5500_0000);
        apb(0, dout_addr(5, 1), 0, rd, er, wt);
        check("dout_hit_waits", wt, 0);
        check("dout_hit_data", rd, 32'h5500_0001);
        apb(0, 32'h3008, 0, rd, er, wt);
        check("status_hit_last", rd, 32'h8);
        drra_write(6'd5, 32'h5B00_0000);
        apb(0, dout_addr(5, 1), 0, rd, er, wt);
        check("dout_inval_waits", wt >= 2, 1);
        check("dout_inval_data", rd, 32'h5B00_0001);
        apb(1, dout_addr(5, 1), 32'hFFFF_FFFF, rd, er, wt);
        check("dout_write_okay", er, 0);

        // Call / ret handshake with interrupt enabled.
        apb(1, 32'h300C, 32'h1, rd, er, wt);
        apb(1, 32'h3004, 32'h1, rd, er, wt);
        check("call_err", er, 0);
        #3;
        check("call_pulse", call, 1);
        @(posedge clk); #4;
        check("call_pulse_end", call, 0);
        apb(0, 32'h3008, 0, rd, er, wt);
        check("status_busy", rd, 32'h1);
        apb(1, 32'h3004, 32'h1, rd, er, wt);
        check("call_busy_err", er, 1);
        @(posedge clk); #1 ret = 1'b1;
        @(posedge clk); #1 ret = 1'b0;
        @(posedge clk); #4;
        check("irq_set", irq, 1);
        apb(0, 32'h3008, 0, rd, er, wt);
        check("status_done", rd, 32'h2);
        @(posedge clk); #4;
        check("irq_cleared", irq, 0);
        apb(0, 32'h3008, 0, rd, er, wt);
        check("status_after_done", rd, 32'h0);

        // Range-checked select and unmapped address.
        apb(1, 32'h3000, 32'h0000_0001, rd, er, wt);
        check("sel_row_err", er, 1);
        apb(1, 32'h3000, 32'h0002_0000, rd, er, wt);
        check("sel_col_err", er, 1);
        apb(1, 32'h5000, 32'h0000_0000, rd, er, wt);
        check("unmapped_wr_err", er, 1);
        apb(0, 32'h5000, 0, rd, er, wt);
        check("unmapped_rd_err", er, 1);
        check("unmapped_rd_data", rd, 0);
        apb(0, 32'h3000, 0, rd, er, wt);
        check("sel_unchanged", rd, 32'h0001_0000);

        // Reset while the cache FSM is fetching.
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = dout_addr(6, 0);
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1;
        rst = 1; psel = 0; penable = 0;
        @(posedge clk); #1 rst = 0;
        #3;
        check("rst_fetch_pready", pready, 1);
        check("rst_fetch_irq", irq, 0);
        apb(0, 32'h3000, 0, rd, er, wt);
        check("rst_sel", rd, 0);
        apb(0, dout_addr(5, 2), 0, rd, er, wt);
        check("rst_cache_miss", wt >= 2, 1);
        check("rst_cache_data", rd, 32'h5B00_0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
